// File: rtl/cdb_arbiter_if.sv
// Bus bundle between the functional units and the CDB arbiter: per-FU requests and grants,
// plus the registered broadcast seen by the reservation stations and the ROB.
interface cdb_arbiter_if #(
   parameter int NUM_FU = 4,
   parameter int ID_W   = 4,
   parameter int VAL_W  = 8
);
   logic [NUM_FU-1:0]             req;
   logic [NUM_FU-1:0][ID_W-1:0]   req_id;
   logic [NUM_FU-1:0][VAL_W-1:0]  req_val;
   logic                          cdb_stall;
   logic [NUM_FU-1:0]             grant;
   logic                          cdb_valid;
   logic [ID_W-1:0]               cdb_id;
   logic [VAL_W-1:0]              cdb_val;

   // The functional units and the broadcast consumers sit on the master side
   modport master (
      output req, req_id, req_val, cdb_stall,
      input  grant, cdb_valid, cdb_id, cdb_val
   );

   modport slave (
      input  req, req_id, req_val, cdb_stall,
      output grant, cdb_valid, cdb_id, cdb_val
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one combinational one-hot grant per cycle, registered broadcast.
// Optional saturating statistics counters are built only when CDB_STATS_EN is defined.
module cdb_arbiter #(
   parameter int NUM_FU = 4,
   parameter int ID_W   = 4,
   parameter int VAL_W  = 8
) (
   input  logic        clk,
   input  logic        rst,
   cdb_arbiter_if.slave bus,
   output logic [15:0] stat_grants,
   output logic [15:0] stat_conflicts
);
   localparam int PTR_W = $clog2(NUM_FU);

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  ptr_next;
   logic [PTR_W-1:0]  grant_idx;
   logic              grant_any;
   logic [NUM_FU-1:0] grant_vec;
   logic              valid_q;
   logic [ID_W-1:0]   id_q;
   logic [VAL_W-1:0]  val_q;

   // Scan from ptr upward (mod NUM_FU); the first requester wins. Reset and stall suppress grants.
   always_comb begin : arb_scan
      logic [PTR_W-1:0] idx;
      idx       = '0;
      grant_vec = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      if (!rst && !bus.cdb_stall) begin
         for (int k = 0; k < NUM_FU; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_FU);
            if (!grant_any && bus.req[idx]) begin
               grant_any      = 1'b1;
               grant_idx      = idx;
               grant_vec[idx] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ptr_next = ptr;
      if (grant_any) begin
         ptr_next = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         val_q   <= '0;
      end else begin
         valid_q <= grant_any;
         ptr     <= ptr_next;
         if (grant_any) begin
            id_q  <= bus.req_id[grant_idx];
            val_q <= bus.req_val[grant_idx];
         end
      end
   end

   assign bus.grant     = grant_vec;
   assign bus.cdb_valid = valid_q;
   assign bus.cdb_id    = id_q;
   assign bus.cdb_val   = val_q;

`ifdef CDB_STATS_EN
   logic [15:0] grants_q;
   logic [15:0] conflicts_q;
   logic        multi_req;

   assign multi_req = ($countones(bus.req) >= 2);

   // Both counters stick at all-ones rather than wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grants_q    <= '0;
         conflicts_q <= '0;
      end else begin
         if (grant_any && (grants_q != 16'hFFFF)) begin
            grants_q <= grants_q + 16'd1;
         end
         if (multi_req && !bus.cdb_stall && (conflicts_q != 16'hFFFF)) begin
            conflicts_q <= conflicts_q + 16'd1;
         end
      end
   end

   assign stat_grants    = grants_q;
   assign stat_conflicts = conflicts_q;
`else
   assign stat_grants    = '0;
   assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic,
// checked against a distance-from-pointer reference model.
module tb_cdb_arbiter;
   localparam int NUM_FU = 4;
   localparam int ID_W   = 4;
   localparam int VAL_W  = 8;
`ifdef CDB_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] stat_grants;
   logic [15:0] stat_conflicts;

   int total;
   int bad;

   int          m_ptr;
   logic        m_valid;
   logic [31:0] m_id;
   logic [31:0] m_val;
   int          m_grants;
   int          m_conflicts;

   cdb_arbiter_if #(.NUM_FU(NUM_FU), .ID_W(ID_W), .VAL_W(VAL_W)) bus ();

   cdb_arbiter #(.NUM_FU(NUM_FU), .ID_W(ID_W), .VAL_W(VAL_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus.slave),
      .stat_grants    (stat_grants),
      .stat_conflicts (stat_conflicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_ptr       = 0;
      m_valid     = 1'b0;
      m_id        = 0;
      m_val       = 0;
      m_grants    = 0;
      m_conflicts = 0;
   endtask

   // Winner is the requester at the smallest forward distance from the pointer
   function automatic logic [NUM_FU-1:0] modelGrant();
      int best;
      int best_dist;
      int d;
      logic [NUM_FU-1:0] g;
      g = '0;
      best = -1;
      best_dist = NUM_FU;
      if (!rst && !bus.cdb_stall) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (bus.req[i]) begin
               d = (i - m_ptr + NUM_FU) % NUM_FU;
               if (d < best_dist) begin
                  best_dist = d;
                  best = i;
               end
            end
         end
         if (best >= 0) g[best] = 1'b1;
      end
      return g;
   endfunction

   task automatic modelUpdate(input logic [NUM_FU-1:0] g);
      m_valid = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (g[i]) begin
            m_valid = 1'b1;
            m_id    = 32'(bus.req_id[i]);
            m_val   = 32'(bus.req_val[i]);
            m_ptr   = (i + 1) % NUM_FU;
         end
      end
      if (m_valid && m_grants < 65535) m_grants++;
      if ($countones(bus.req) >= 2 && !bus.cdb_stall && m_conflicts < 65535) m_conflicts++;
   endtask

   task automatic randomizePayload();
      for (int i = 0; i < NUM_FU; i++) begin
         bus.req_id[i]  = ID_W'($urandom);
         bus.req_val[i] = VAL_W'($urandom);
      end
   endtask

   // Called just after a rising edge; returns just after the next rising edge
   task automatic applyStimulus(input logic [NUM_FU-1:0] r, input logic s);
      logic [NUM_FU-1:0] exp_grant;
      bus.req       = r;
      bus.cdb_stall = s;
      @(negedge clk);
      exp_grant = modelGrant();
      checkOutput("grant", 32'(bus.grant), 32'(exp_grant));
      @(posedge clk);
      modelUpdate(exp_grant);
      #1;
      checkOutput("cdb_valid", 32'(bus.cdb_valid), 32'(m_valid));
      checkOutput("cdb_id", 32'(bus.cdb_id), m_id);
      checkOutput("cdb_val", 32'(bus.cdb_val), m_val);
      checkOutput("stat_grants", 32'(stat_grants), STATS_EN ? 32'(m_grants) : 32'd0);
      checkOutput("stat_conflicts", 32'(stat_conflicts), STATS_EN ? 32'(m_conflicts) : 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.req       = '0;
      bus.cdb_stall = 1'b0;
      randomizePayload();
      modelReset();

      @(posedge clk);
      #1;
      bus.req = 4'b1111;
      #2;
      checkOutput("rst_grant", 32'(bus.grant), 32'd0);
      checkOutput("rst_valid", 32'(bus.cdb_valid), 32'd0);
      checkOutput("rst_id", 32'(bus.cdb_id), 32'd0);
      checkOutput("rst_val", 32'(bus.cdb_val), 32'd0);
      checkOutput("rst_stat_grants", 32'(stat_grants), 32'd0);
      checkOutput("rst_stat_conflicts", 32'(stat_conflicts), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset mid-broadcast");
      applyStimulus(4'b1111, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_valid", 32'(bus.cdb_valid), 32'd0);
      checkOutput("async_rst_grant", 32'(bus.grant), 32'd0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req = 4'b1111;
      #1;
      checkOutput("post_rst_first_grant", 32'(bus.grant), 32'h1);
      applyStimulus(4'b1111, 1'b0);

      $display("[TB] single request");
      randomizePayload();
      bus.req_id[2]  = 4'h9;
      bus.req_val[2] = 8'h3C;
      applyStimulus(4'b0100, 1'b0);
      checkOutput("single_id", 32'(bus.cdb_id), 32'h9);
      checkOutput("single_val", 32'(bus.cdb_val), 32'h3C);

      $display("[TB] full contention");
      for (int c = 0; c < 8; c++) begin
         randomizePayload();
         applyStimulus(4'b1111, 1'b0);
      end

      $display("[TB] pointer wrap");
      applyStimulus(4'b1000, 1'b0);
      bus.req = 4'b1001;
      #1;
      checkOutput("wrap_to_fu0", 32'(bus.grant), 32'h1);
      applyStimulus(4'b1001, 1'b0);
      bus.req = 4'b1000;
      #1;
      checkOutput("wrap_then_fu3", 32'(bus.grant), 32'h8);
      applyStimulus(4'b1000, 1'b0);

      $display("[TB] single requester back to back");
      for (int c = 0; c < 3; c++) applyStimulus(4'b0001, 1'b0);

      $display("[TB] stall");
      for (int c = 0; c < 3; c++) applyStimulus(4'b0010, 1'b1);
      bus.cdb_stall = 1'b0;
      #1;
      checkOutput("stall_release_grant", 32'(bus.grant), 32'h2);
      applyStimulus(4'b0010, 1'b0);

      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         randomizePayload();
         applyStimulus(NUM_FU'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
      end

`ifdef CDB_STATS_EN
      $display("[TB] counter saturation");
      for (int c = 0; c < 65537; c++) applyStimulus(4'b0011, 1'b0);
      checkOutput("sat_grants", 32'(stat_grants), 32'hFFFF);
      checkOutput("sat_conflicts", 32'(stat_conflicts), 32'hFFFF);
      applyStimulus(4'b0011, 1'b0);
      checkOutput("sat_grants_hold", 32'(stat_grants), 32'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
